// File: rtl/flow_led_multi.sv
// flow_led_multi: LED_NUM-wide flow light with four run-time patterns,
// programmable step prescaler, pause, speed scaling and output polarity.
module flow_led_multi #(
    parameter int LED_NUM  = 4,
    parameter int STEP_CNT = 25_000_000,
    parameter bit LED_ACT  = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    output logic [LED_NUM-1:0] led,
    output logic               step
);

    localparam int CW = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;

    typedef enum logic [1:0] {
        M_ROL  = 2'b00,
        M_ROR  = 2'b01,
        M_PING = 2'b10,
        M_BAR  = 2'b11
    } mode_e;

    localparam logic [LED_NUM-1:0] LSB_ONE = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] MSB_ONE = LSB_ONE << (LED_NUM - 1);

    logic [CW-1:0]      cnt_q,  cnt_d;
    logic [LED_NUM-1:0] pat_q,  pat_d;
    logic [LED_NUM-1:0] led_q,  led_d;
    mode_e              mode_q, mode_d;
    logic               down_q, down_d;
    logic               step_q, step_d;
    logic [31:0]        term;
    logic               tick;

    // Starting pattern each mode loads when it is first selected.
    function automatic logic [LED_NUM-1:0] init_pat(input mode_e m);
        logic [LED_NUM-1:0] p;
        unique case (m)
            M_ROL:   p = LSB_ONE;
            M_ROR:   p = MSB_ONE;
            M_PING:  p = LSB_ONE;
            M_BAR:   p = '0;
            default: p = LSB_ONE;
        endcase
        return p;
    endfunction

    // Prescaler terminal compare; >= lets a speed raise tick at once.
    always_comb begin
        term = (32'(STEP_CNT) >> speed) - 32'd1;
        tick = en && (32'(cnt_q) >= term);
    end

    // Next-state logic for counter, pattern, mode, direction and strobe.
    always_comb begin
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        mode_d = mode_q;
        down_d = down_q;
        step_d = 1'b0;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        if (tick) begin
            step_d = 1'b1;
            if (mode != mode_q) begin
                // A new mode restarts from its own init pattern.
                mode_d = mode_e'(mode);
                pat_d  = init_pat(mode_e'(mode));
                down_d = 1'b0;
            end else begin
                unique case (mode_q)
                    M_ROL: begin
                        pat_d = (pat_q << 1) | (pat_q >> (LED_NUM - 1));
                    end
                    M_ROR: begin
                        pat_d = (pat_q >> 1) | (pat_q << (LED_NUM - 1));
                    end
                    M_PING: begin
                        if (LED_NUM > 1) begin
                            if (!down_q) begin
                                pat_d = pat_q << 1;
                                if (pat_d[LED_NUM-1]) begin
                                    down_d = 1'b1;
                                end
                            end else begin
                                pat_d = pat_q >> 1;
                                if (pat_d[0]) begin
                                    down_d = 1'b0;
                                end
                            end
                        end
                    end
                    M_BAR: begin
                        if (&pat_q) begin
                            pat_d = '0;
                        end else begin
                            pat_d = (pat_q << 1) | LSB_ONE;
                        end
                    end
                    default: pat_d = pat_q;
                endcase
            end
        end

        led_d = LED_ACT ? pat_d : ~pat_d;
    end

    // State registers; led and step are registered together with pattern.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q  <= '0;
            pat_q  <= LSB_ONE;
            mode_q <= M_ROL;
            down_q <= 1'b0;
            step_q <= 1'b0;
            led_q  <= LED_ACT ? LSB_ONE : ~LSB_ONE;
        end else begin
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            mode_q <= mode_d;
            down_q <= down_d;
            step_q <= step_d;
            led_q  <= led_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_flow_led_multi.sv
// tb_flow_led_multi: directed vectors for flow_led_multi,
// an active-high and an active-low build driven in parallel.
module tb_flow_led_multi;

    logic       clk;
    logic       sys_rst;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [3:0] led;
    logic [3:0] led_n;
    logic       step;
    logic       step_n;

    int nvec = 0;
    int nerr = 0;

    flow_led_multi #(.LED_NUM(4), .STEP_CNT(8), .LED_ACT(1'b1)) dut (
        .sys_clk(clk),
        .sys_rst(sys_rst),
        .en(en),
        .mode(mode),
        .speed(speed),
        .led(led),
        .step(step)
    );

    flow_led_multi #(.LED_NUM(4), .STEP_CNT(8), .LED_ACT(1'b0)) dut_n (
        .sys_clk(clk),
        .sys_rst(sys_rst),
        .en(en),
        .mode(mode),
        .speed(speed),
        .led(led_n),
        .step(step_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            edge1();
            if (step) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic expect_step(input string tag, input int gap,
                               input logic [3:0] e);
        int n;
        wait_step(20, n);
        check({tag, "_gap"}, n, gap);
        check({tag, "_led"}, led, e);
        check({tag, "_ledn"}, led_n, 4'(~e));
        check({tag, "_stepn"}, step_n, 1'b1);
    endtask

    task automatic quiet(input string tag, input int cyc,
                         input logic [3:0] e);
        int seen;
        seen = 0;
        for (int i = 0; i < cyc; i++) begin
            edge1();
            if (step) seen++;
        end
        check({tag, "_nstep"}, seen, 0);
        check({tag, "_led"}, led, e);
    endtask

    logic [3:0] rol_v [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] ror_v [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [3:0] png_v [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] bar_v [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                              4'b1111, 4'b0000, 4'b0001, 4'b0011};
    logic [3:0] pp2_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};

    initial begin
        sys_rst = 1'b1;
        en      = 1'b1;
        mode    = 2'b00;
        speed   = 2'b00;

        // Reset state and first step
        repeat (3) edge1();
        check("rst_led", led, 4'b0001);
        check("rst_ledn", led_n, 4'b1110);
        check("rst_step", step, 1'b0);
        sys_rst = 1'b0;
        expect_step("first", 8, 4'b0010);

        // Rotate left at speed 0
        foreach (rol_v[i]) expect_step("rol", 8, rol_v[i]);

        // Speed raised while cnt is past the new terminal count
        quiet("pre_spd", 5, 4'b0010);
        speed = 2'd2;
        expect_step("spd_now", 1, 4'b0100);
        expect_step("spd2", 2, 4'b1000);

        // Rotate right; first tick only loads 1000
        mode = 2'b01;
        foreach (ror_v[i]) expect_step("ror", 2, ror_v[i]);

        // Ping-pong from reset
        speed   = 2'd0;
        mode    = 2'b10;
        sys_rst = 1'b1;
        edge1();
        sys_rst = 1'b0;
        check("rst2_led", led, 4'b0001);
        foreach (png_v[i]) expect_step("png", 8, png_v[i]);

        // Bar-fill then switch to rotate left mid-sequence
        mode = 2'b11;
        foreach (bar_v[i]) expect_step("bar", 8, bar_v[i]);
        mode = 2'b00;
        quiet("mchg", 4, 4'b0011);
        expect_step("mchg_load", 4, 4'b0001);

        // Pause at cnt=3 for 20 cycles
        quiet("pre_pause", 3, 4'b0001);
        en = 1'b0;
        quiet("pause", 20, 4'b0001);
        en = 1'b1;
        expect_step("resume", 5, 4'b0010);

        // Reset mid-step while ping-pong is heading down
        mode = 2'b10;
        foreach (pp2_v[i]) expect_step("pp2", 8, pp2_v[i]);
        quiet("pre_rst", 5, 4'b0100);
        sys_rst = 1'b1;
        edge1();
        check("mrst_led", led, 4'b0001);
        check("mrst_ledn", led_n, 4'b1110);
        check("mrst_step", step, 1'b0);
        sys_rst = 1'b0;
        mode    = 2'b00;
        expect_step("post_rst", 8, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
